// File: rtl/print_job_queue.sv
// print_job_queue: FIFO of host print jobs feeding the print engine one job at a time.
// Each job is dispatched as a single-cycle push/pages strobe. Completion is tracked by
// counting rising edges of printpage, then an inter-job gap is enforced before the next
// dispatch.
// Optional watchdog: define PRINT_JOB_TIMEOUT_EN to abort jobs whose pages stall for
// TIMEOUT clocks. An abort raises a sticky fault.
module print_job_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned GAP_CYCLES = 3,
  parameter int unsigned TIMEOUT    = 200
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     job_valid,
  input  logic [7:0]               job_pages,
  output logic                     job_ready,
  output logic                     job_reject,
  output logic                     push,
  output logic [7:0]               pages,
  input  logic                     printpage,
  output logic                     busy,
  output logic [7:0]               pages_left,
  output logic                     job_done,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic                     fault
);

  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned GapLoad = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;
  localparam int unsigned GapW    = (GapLoad < 2) ? 1 : $clog2(GapLoad + 1);

  typedef enum logic [1:0] {StIdle, StDispatch, StPrinting, StGap} state_e;

  state_e              state_q, state_d;
  logic [7:0]          mem_q [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q;
  logic                pp_q;
  logic [7:0]          left_q, left_d;
  logic                done_q, done_d;
  logic                reject_q;
  logic [GapW-1:0]     gap_q, gap_d;
  logic                enq, pop, pp_edge, timeout;

  // job_ready comes from the pre-pop count, so a full queue never accepts in a pop cycle
  assign job_ready = (count_q != CntW'(DEPTH));
  assign enq       = job_valid && job_ready && (job_pages != 8'd0);
  assign pop       = (state_q == StDispatch);
  assign pp_edge   = printpage && !pp_q;

  // FIFO pointers, occupancy and the registered printpage for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pp_q     <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q  <= count_q + CntW'(enq) - CntW'(pop);
      pp_q     <= printpage;
      reject_q <= job_valid && (job_pages == 8'd0);
    end
  end

  // FIFO storage; contents are don't-care while the slot is empty
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= job_pages;
  end

`ifdef PRINT_JOB_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           fault_q, fault_d;

  // TIMEOUT-th consecutive PRINTING cycle without a page edge
  assign timeout = (state_q == StPrinting) && !pp_edge && (wd_q == WdW'(TIMEOUT - 1));
  assign fault   = fault_q;

  // Watchdog next state: cleared on dispatch and every counted page edge
  always_comb begin
    wd_d    = wd_q;
    fault_d = fault_q;
    if (state_q == StDispatch) begin
      wd_d = '0;
    end else if (state_q == StPrinting) begin
      wd_d = pp_edge ? '0 : wd_q + WdW'(1);
    end
    if (timeout) fault_d = 1'b1;
  end

  // Watchdog registers; fault stays set until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      fault_q <= fault_d;
    end
  end
`else
  assign timeout = 1'b0;
  assign fault   = 1'b0;
`endif

  // Job sequencing next state
  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) state_d = StDispatch;
      end
      StDispatch: begin
        left_d  = mem_q[rd_ptr_q];
        state_d = StPrinting;
      end
      StPrinting: begin
        if (pp_edge) begin
          left_d = left_q - 8'd1;
          if (left_q == 8'd1) begin
            done_d  = 1'b1;
            gap_d   = GapW'(GapLoad);
            state_d = (GAP_CYCLES == 0) ? StIdle : StGap;
          end
        end else if (timeout) begin
          left_d  = 8'd0;
          gap_d   = GapW'(GapLoad);
          state_d = (GAP_CYCLES == 0) ? StIdle : StGap;
        end
      end
      StGap: begin
        if (gap_q == '0) state_d = StIdle;
        else             gap_d   = gap_q - GapW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  // Job sequencing registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      left_q  <= 8'd0;
      gap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
    end
  end

  assign push        = pop;
  assign pages       = pop ? mem_q[rd_ptr_q] : 8'd0;
  assign busy        = (state_q != StIdle);
  assign pages_left  = left_q;
  assign job_done    = done_q;
  assign job_reject  = reject_q;
  assign queue_count = count_q;

endmodule

// File: doc/print_job_queue.md
Name: print_job_queue

Overview:
- Upstream feeder for the `print` engine.
- Buffers host print jobs (a page count each) in a FIFO and dispatches them one at a time: a single-cycle `push` with `pages` valid.
- Tracks completion by counting rising edges of the engine's `printpage`, then enforces an inter-job gap before dispatching the next job.
- Sits between the host request interface and the `print` push/pages inputs.

Parameters:
- DEPTH, 4, FIFO job slots; power of 2, ≥ 2.
- GAP_CYCLES, 3, idle clocks between job completion and the next dispatch; 0 allowed.
- TIMEOUT, 200, max clocks between consecutive `printpage` rising edges, counted from dispatch for the first page; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- job_valid  in  1  host offers a job this cycle.
- job_pages  in  8  page count of the offered job.
- job_ready  out  1  queue can accept; equals !full.
- job_reject  out  1  one-cycle pulse: offered job had job_pages==0 and was dropped.
- push  out  1  one-cycle dispatch strobe to the print engine.
- pages  out  8  page count to the engine; nonzero only while push=1.
- printpage  in  1  engine print indicator; each rising edge counts as one page printed.
- busy  out  1  high from dispatch cycle until the GAP ends.
- pages_left  out  8  pages remaining in the current job; 0 when not printing.
- job_done  out  1  one-cycle pulse when the last page edge is seen.
- queue_count  out  log2(DEPTH)+1  jobs currently stored.
- fault  out  1  sticky watchdog fault; optional feature only, else tied 0.

Behaviour:
- Synchronous reset, active-high:
  - FIFO emptied; FSM goes to IDLE; all counters cleared.
  - Outputs: push=0, pages=0, busy=0, pages_left=0, job_done=0, job_reject=0, fault=0, queue_count=0, job_ready=1.
- Reset mid-job discards the in-flight job and all queued jobs; no job_done is issued.
- Enqueue:
  - Occurs on job_valid && job_ready && job_pages!=0; queue_count increments next cycle.
  - job_valid && job_pages==0 → no enqueue; job_reject=1 next cycle, regardless of fullness.
  - job_valid while full → ignored silently; the host must hold the request.
- Edge detect: printpage is registered once (pp_q). An edge is printpage && !pp_q, sampled only in PRINTING.
- FSM states:
  - IDLE: if queue_count>0 → DISPATCH.
  - DISPATCH (one cycle):
    - push=1, pages=FIFO head; pop the head.
    - pages_left loads head value; busy=1.
    - Next state PRINTING.
  - PRINTING:
    - Each edge decrements pages_left.
    - An edge while pages_left==1 → job_done=1 next cycle, pages_left=0, go to GAP.
  - GAP: wait GAP_CYCLES clocks, busy=1, then go to IDLE with busy=0. If GAP_CYCLES==0, go directly to IDLE.
- Latency:
  - With a job queued and the FSM in IDLE, push asserts 1 clock after entering IDLE.
  - First dispatch after enqueue into an empty idle queue: push asserts 2 clocks after the enqueue edge.
- Simultaneous enqueue and pop in the same cycle: both take effect; queue_count unchanged.
  - A full queue does not accept in the pop cycle, because job_ready is derived from the pre-pop count.
- Edges seen in IDLE/DISPATCH/GAP are ignored.
- Pointers wrap modulo DEPTH. queue_count never exceeds DEPTH.
- Widths: pages_left is 8-bit, so the maximum job size is 255. Decrement never underflows, because exit occurs at 1.

Optional Feature:
- Macro: PRINT_JOB_TIMEOUT_EN.
- When defined:
  - A watchdog counter resets on DISPATCH and on every counted edge, and increments each PRINTING cycle.
  - On reaching TIMEOUT: abort the job, set fault=1 (sticky until rst), pages_left=0, no job_done, go to GAP.
  - The queue keeps dispatching after a fault.
- When undefined:
  - No watchdog logic; fault tied 0.
  - PRINTING waits indefinitely.

Test Plan:
- Reset then idle, no jobs for 20 clocks → push=0, busy=0, job_ready=1, queue_count=0, all outputs 0.
- Enqueue job_pages=70; drive 70 printpage pulses (1 high / 9 low) →
  - push=1 with pages=70 exactly once, 2 clocks after enqueue.
  - pages_left decrements 70→0.
  - job_done pulses once after the 70th edge.
  - busy falls GAP_CYCLES+1 clocks later.
- Enqueue 40, 15, 5, 9, 3 back-to-back while the first job prints →
  - job_ready falls after 4 stored (DEPTH=4, one in flight).
  - Dispatch order is 40, 15, 5, 9, 3.
  - queue_count peaks at 4.
- Offer job_pages=0 → job_reject pulses 1 cycle; queue_count unchanged.
- Assert rst mid-job (pages_left=12, 2 queued) → next cycle: queue_count=0, busy=0, pages_left=0, no job_done; the following printpage edges are ignored.
- With PRINT_JOB_TIMEOUT_EN and TIMEOUT=200: dispatch 5 pages, give 2 edges, then hold printpage low → fault=1 after 200 idle clocks, job aborted, next queued job dispatched after the GAP.
